control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Sequencer that drives the 3-bit instruction buses of datapath registers X, Y and Z, and the ULA operation select. It accepts one operation request (opcode plus 2-bit repeat amount) and expands it into a cycle-by-cycle command sequence. It raises `done` when the sequence completes. It is the initiator side of the register instruction interface; the registers only ever see codes this block emits.

Parameters:
- AMT_W, 2, width of repeat-amount input; step count = amt+1 (1..4).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe, sampled only in IDLE
- op  input  3  opcode, sampled with start
- amt  input  AMT_W  repeat amount, sampled with start
- instr_x  output  3  instruction to register X
- instr_y  output  3  instruction to register Y
- instr_z  output  3  instruction to register Z
- ula_sel  output  2  ULA operation: 00 ADD, 01 SUB, 10 PASS_X, 11 PASS_Y
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Register instruction codes: HOLD 000, LOAD 001, SHIFTR 010, SHIFTL 011, RESET 100. Codes 101–111 are never emitted.
- FSM states and transitions:
  - IDLE: if start=1, go to EXEC.
  - EXEC: if the step counter has reached amt_q: go to STORE when op is MAC, otherwise go to DONE. Else stay in EXEC.
  - STORE: go to DONE.
  - DONE: go to IDLE.
- Request capture: start=1 in IDLE latches op_q and amt_q and clears the step counter at that edge. Outside IDLE, start, op and amt are ignored (no queuing).
- Step counter: increments on each EXEC edge. Single-step ops (NOP, CLR, LDX, ADD, SUB) ignore amt and spend exactly 1 cycle in EXEC.
- Commands are decoded from state and op_q. Default for every output is all instr = HOLD, ula_sel = 00. In EXEC:
  - NOP 000: defaults only.
  - CLR 001: instr_x = instr_y = instr_z = RESET.
  - LDX 010: instr_x = LOAD (X's load source is outside this block).
  - ADD 011: ula_sel = ADD, instr_y = LOAD.
  - SUB 100: ula_sel = SUB, instr_y = LOAD.
  - SHL 101: instr_y = SHIFTL for amt+1 cycles.
  - SHR 110: instr_y = SHIFTR for amt+1 cycles.
  - MAC 111: ula_sel = ADD, instr_y = LOAD for amt+1 cycles, then in STORE: ula_sel = PASS_Y, instr_z = LOAD.
- IDLE and DONE always drive the defaults.
- Register action: each command is valid for a whole cycle and is acted on by the registers at the edge that ends that cycle.
- Status outputs:
  - busy = 1 in EXEC, STORE and DONE; 0 in IDLE.
  - done = 1 only in DONE.
- Latency, counted from the start-accept edge:
  - single-step ops: done is high in the 2nd cycle;
  - SHL/SHR: done is high in cycle amt+2;
  - MAC: done is high in cycle amt+3.
- Back-to-back requests: a start asserted during DONE is ignored. The earliest accept is the IDLE cycle after DONE, so the minimum request spacing is 3 cycles.
- Reset: takes priority over everything, including mid-sequence.
  - Next state IDLE; counter, op_q and amt_q cleared.
  - Outputs after the reset edge: all instr = HOLD, ula_sel = 00, busy = 0, done = 0.
  - Reset does not emit RESET codes to the registers; only CLR clears them.
- Outputs are a pure decode of registered state, with no combinational path from start, op or amt.

Decomposition:
- Shared package `cu_pkg`:
  - register instruction codes (HOLD..RESET);
  - ULA select codes;
  - opcode constants NOP..MAC;
  - FSM state enum (IDLE, EXEC, STORE, DONE).
- The register blocks and the datapath top import the same instruction constants.
- No sub-module. The step counter and the command decode are inline, and the decode is a single case on state/op_q.

Test Plan:
- Reset mid-SHL (amt=3, after 2 EXEC cycles) -> next cycle state IDLE, busy=0, done=0, all instr=000, ula_sel=00; a new start is accepted on the following edge.
- start with op=CLR -> exactly one cycle of instr_x = instr_y = instr_z = 100, then DONE with done=1 for one cycle, busy low the cycle after.
- op=SHL, amt=2 -> instr_y=011 for exactly 3 consecutive cycles, instr_x = instr_z = 000 throughout, done high in cycle 4 after accept.
- op=MAC, amt=1 -> 2 cycles of ula_sel=00 with instr_y=001, then 1 cycle of ula_sel=11 with instr_z=001, done in cycle 4; integrated with registerY/ULA, X=3 and Y=1 gives Z=7.
- start held high continuously with op=ADD -> accepts every 3 cycles; instr_y=001 with ula_sel=00 once per accept; start is ignored in EXEC and DONE.
- Random op/amt over 1000 requests -> instr_* never 101–111, busy matches state, done is a one-cycle pulse, command-cycle count matches the latency formula.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared constants for the control unit and the datapath blocks it drives.
//   - register instruction codes (HOLD..RESET)
//   - ULA operation select codes
//   - opcode constants (NOP..MAC)
//   - control unit FSM state encoding
package cu_pkg;

  typedef enum logic [2:0] {
    INSTR_HOLD   = 3'b000,
    INSTR_LOAD   = 3'b001,
    INSTR_SHIFTR = 3'b010,
    INSTR_SHIFTL = 3'b011,
    INSTR_RESET  = 3'b100
  } instr_e;

  typedef enum logic [1:0] {
    ULA_ADD    = 2'b00,
    ULA_SUB    = 2'b01,
    ULA_PASS_X = 2'b10,
    ULA_PASS_Y = 2'b11
  } ula_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_CLR = 3'b001,
    OP_LDX = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MAC = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_STORE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // NOP, CLR, LDX, ADD and SUB occupy exactly one EXEC cycle regardless of amt.
  function automatic logic is_single_step(input logic [2:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Request and command bundle of the control unit.
//   Request side : start, op, amt
//   Command side : instr_x, instr_y, instr_z, ula_sel
//   Status       : busy, done, dbg_state (current FSM state, for observation)
// Handshake: start is the request valid and ~busy is the ready; a request is
// accepted on the rising edge where start=1 and busy=0. There is no queuing:
// a start seen while busy is dropped, and the requester must keep it high
// (or re-assert it) until busy is low to get it accepted.
// master = control unit side, slave = requester / datapath side.
interface control_unit_if #(
  parameter int AMT_W = 2
);
  import cu_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [2:0]       instr_x;
  logic [2:0]       instr_y;
  logic [2:0]       instr_z;
  logic [1:0]       ula_sel;
  logic             busy;
  logic             done;
  state_e           dbg_state;

  modport master (
    input  start, op, amt,
    output instr_x, instr_y, instr_z, ula_sel, busy, done, dbg_state
  );

  modport slave (
    output start, op, amt,
    input  instr_x, instr_y, instr_z, ula_sel, busy, done, dbg_state
  );

endinterface

// File: rtl/control_unit.sv
// Control unit: expands one operation request (opcode + repeat amount) into a
// cycle-by-cycle command sequence for registers X, Y, Z and the ULA.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high; returns to IDLE, clears captured request
//   cu     - control_unit_if.master: start/op/amt in; instr_x/y/z, ula_sel,
//            busy, done, dbg_state out
// Sequence: IDLE -> EXEC (amt+1 cycles for SHL/SHR/MAC, 1 otherwise)
//           -> STORE (MAC only) -> DONE -> IDLE.
// All outputs decode registered state only; start/op/amt never reach them
// combinationally.
module control_unit
  import cu_pkg::*;
#(
  parameter int AMT_W = 2
) (
  input  logic           clock,
  input  logic           reset,
  control_unit_if.master cu
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;

  logic             exec_last;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Final EXEC cycle: single-step ops always, repeated ops once the counter
  // has caught up with the captured amount.
  assign exec_last = is_single_step(op_q) || (cnt_q == amt_q);

  // ---------------------------------------------------------------------------
  // Next-state and request capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cu.start) begin
          state_d = ST_EXEC;
          op_d    = cu.op;
          amt_d   = cu.amt;
          cnt_d   = '0;
        end
      end
      ST_EXEC: begin
        // The counter wraps after the last step of amt=max; it is cleared on
        // the next accept, so the wrapped value is never used.
        cnt_d = cnt_q + 1'b1;
        if (exec_last) begin
          state_d = (op_q == OP_MAC) ? ST_STORE : ST_DONE;
        end
      end
      ST_STORE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command / status decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cu.instr_x   = INSTR_HOLD;
    cu.instr_y   = INSTR_HOLD;
    cu.instr_z   = INSTR_HOLD;
    cu.ula_sel   = ULA_ADD;
    cu.busy      = (state_q != ST_IDLE);
    cu.done      = (state_q == ST_DONE);
    cu.dbg_state = state_q;
    unique case (state_q)
      ST_EXEC: begin
        unique case (op_q)
          OP_CLR: begin
            cu.instr_x = INSTR_RESET;
            cu.instr_y = INSTR_RESET;
            cu.instr_z = INSTR_RESET;
          end
          OP_LDX: cu.instr_x = INSTR_LOAD;
          OP_ADD: begin
            cu.ula_sel = ULA_ADD;
            cu.instr_y = INSTR_LOAD;
          end
          OP_SUB: begin
            cu.ula_sel = ULA_SUB;
            cu.instr_y = INSTR_LOAD;
          end
          OP_SHL: cu.instr_y = INSTR_SHIFTL;
          OP_SHR: cu.instr_y = INSTR_SHIFTR;
          OP_MAC: begin
            // Accumulate Y += X each step
            cu.ula_sel = ULA_ADD;
            cu.instr_y = INSTR_LOAD;
          end
          default: ;  // NOP
        endcase
      end
      ST_STORE: begin
        // Write the accumulated Y into Z through the ULA
        cu.ula_sel = ULA_PASS_Y;
        cu.instr_z = INSTR_LOAD;
      end
      default: ;  // IDLE and DONE drive defaults
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import cu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  control_unit_if #(.AMT_W(2)) cu_bus ();

  control_unit #(.AMT_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .cu    (cu_bus)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // Small datapath model (registers X, Y, Z and the ULA) driven by the commands
  logic [7:0] x_src = '0;
  logic [7:0] reg_x = '0;
  logic [7:0] reg_y = '0;
  logic [7:0] reg_z = '0;
  logic [7:0] ula_res;

  always_comb begin
    case (cu_bus.ula_sel)
      2'b00:   ula_res = reg_x + reg_y;
      2'b01:   ula_res = reg_y - reg_x;
      2'b10:   ula_res = reg_x;
      default: ula_res = reg_y;
    endcase
  end

  always @(posedge clock) begin
    case (cu_bus.instr_x)
      3'b001: reg_x <= x_src;
      3'b010: reg_x <= reg_x >> 1;
      3'b011: reg_x <= reg_x << 1;
      3'b100: reg_x <= '0;
      default: ;
    endcase
    case (cu_bus.instr_y)
      3'b001: reg_y <= ula_res;
      3'b010: reg_y <= reg_y >> 1;
      3'b011: reg_y <= reg_y << 1;
      3'b100: reg_y <= '0;
      default: ;
    endcase
    case (cu_bus.instr_z)
      3'b001: reg_z <= ula_res;
      3'b010: reg_z <= reg_z >> 1;
      3'b011: reg_z <= reg_z << 1;
      3'b100: reg_z <= '0;
      default: ;
    endcase
  end

  // Observed vector: {instr_x, instr_y, instr_z, ula_sel, busy, done}
  logic [12:0] obs;
  assign obs = {cu_bus.instr_x, cu_bus.instr_y, cu_bus.instr_z,
                cu_bus.ula_sel, cu_bus.busy, cu_bus.done};

  localparam logic [12:0] V_IDLE = 13'b000_000_000_00_0_0;
  localparam logic [12:0] V_DONE = 13'b000_000_000_00_1_1;

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [2:0] op, input logic [1:0] amt, input int cycles);
    cu_bus.start = 1'b1;
    cu_bus.op    = op;
    cu_bus.amt   = amt;
    step();
    cu_bus.start = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Expected vector for cycle k after the accept edge (k=1 is the first EXEC cycle)
  function automatic logic [12:0] exp_vec(input logic [2:0] op, input logic [1:0] amt, input int k);
    logic [2:0] x, y, z;
    logic [1:0] u;
    logic       b, d;
    int         n, lat;
    x = 3'd0; y = 3'd0; z = 3'd0; u = 2'd0; b = 1'b0; d = 1'b0;
    n   = (op >= 3'd5) ? int'(amt) + 1 : 1;
    lat = (op <= 3'd4) ? 2 : ((op == 3'd7) ? int'(amt) + 3 : int'(amt) + 2);
    if (k >= 1 && k <= lat) b = 1'b1;
    if (k == lat) d = 1'b1;
    if (k >= 1 && k <= n) begin
      case (op)
        3'd1: begin x = 3'd4; y = 3'd4; z = 3'd4; end
        3'd2: x = 3'd1;
        3'd3: begin y = 3'd1; u = 2'd0; end
        3'd4: begin y = 3'd1; u = 2'd1; end
        3'd5: y = 3'd3;
        3'd6: y = 3'd2;
        3'd7: begin y = 3'd1; u = 2'd0; end
        default: ;
      endcase
    end
    if (op == 3'd7 && k == n + 1) begin
      u = 2'd3;
      z = 3'd1;
    end
    return {x, y, z, u, b, d};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset        = 1'b1;
    cu_bus.start = 1'b1;  // must be ignored while reset is high
    cu_bus.op    = 3'd1;
    cu_bus.amt   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== V_IDLE || cu_bus.dbg_state !== ST_IDLE) begin
        failures++;
        $display("FAIL reset_out cyc=%0d got=%b state=%0d exp=%b state=0", i, obs, cu_bus.dbg_state, V_IDLE);
      end
    end
    cu_bus.start = 1'b0;
    reset        = 1'b0;
    step();
    checks++;
    if (obs !== V_IDLE) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs, V_IDLE);
    end
  endtask

  task automatic test_clr();
    logic [12:0] exp_t [4];
    exp_t[0] = 13'b100_100_100_00_1_0;
    exp_t[1] = V_DONE;
    exp_t[2] = V_IDLE;
    exp_t[3] = V_IDLE;
    cu_bus.start = 1'b1; cu_bus.op = 3'd1; cu_bus.amt = 2'd3;
    step();
    cu_bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== exp_t[k]) begin
        failures++;
        $display("FAIL clr cyc=%0d got=%b exp=%b", k + 1, obs, exp_t[k]);
      end
      step();
    end
  endtask

  task automatic test_shl();
    logic [12:0] exp_t [5];
    exp_t[0] = 13'b000_011_000_00_1_0;
    exp_t[1] = 13'b000_011_000_00_1_0;
    exp_t[2] = 13'b000_011_000_00_1_0;
    exp_t[3] = V_DONE;
    exp_t[4] = V_IDLE;
    cu_bus.start = 1'b1; cu_bus.op = 3'd5; cu_bus.amt = 2'd2;
    step();
    cu_bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs !== exp_t[k]) begin
        failures++;
        $display("FAIL shl cyc=%0d got=%b exp=%b", k + 1, obs, exp_t[k]);
      end
      step();
    end
  endtask

  task automatic test_mac_datapath();
    logic [12:0] exp_t [5];
    exp_t[0] = 13'b000_001_000_00_1_0;
    exp_t[1] = 13'b000_001_000_00_1_0;
    exp_t[2] = 13'b000_000_001_11_1_0;
    exp_t[3] = V_DONE;
    exp_t[4] = V_IDLE;
    // Build X=3, Y=1: CLR, X<=1, Y<=X+Y, X<=3
    do_req(3'd1, 2'd0, 2);
    x_src = 8'd1;
    do_req(3'd2, 2'd0, 2);
    do_req(3'd3, 2'd0, 2);
    x_src = 8'd3;
    do_req(3'd2, 2'd0, 2);
    checks++;
    if (reg_x !== 8'd3 || reg_y !== 8'd1) begin
      failures++;
      $display("FAIL mac_setup got x=%0d y=%0d exp x=3 y=1", reg_x, reg_y);
    end
    cu_bus.start = 1'b1; cu_bus.op = 3'd7; cu_bus.amt = 2'd1;
    step();
    cu_bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs !== exp_t[k]) begin
        failures++;
        $display("FAIL mac cyc=%0d got=%b exp=%b", k + 1, obs, exp_t[k]);
      end
      step();
    end
    checks++;
    if (reg_z !== 8'd7 || reg_y !== 8'd7) begin
      failures++;
      $display("FAIL mac_result got z=%0d y=%0d exp z=7 y=7", reg_z, reg_y);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_t [3];
    exp_t[0] = V_IDLE;                     // k%3==0
    exp_t[1] = 13'b000_001_000_00_1_0;     // k%3==1 : ADD in EXEC
    exp_t[2] = V_DONE;                     // k%3==2
    cu_bus.start = 1'b1; cu_bus.op = 3'd3; cu_bus.amt = 2'd0;
    step();
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (obs !== exp_t[k % 3]) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, obs, exp_t[k % 3]);
      end
      // op changes while busy must not be picked up
      cu_bus.op  = (k % 3 == 0) ? 3'd3 : 3'd5;
      cu_bus.amt = (k % 3 == 0) ? 2'd0 : 2'd3;
      step();
    end
    cu_bus.start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    cu_bus.start = 1'b1; cu_bus.op = 3'd5; cu_bus.amt = 2'd3;
    step();
    cu_bus.start = 1'b0;
    step();  // second EXEC cycle
    checks++;
    if (obs !== 13'b000_011_000_00_1_0) begin
      failures++;
      $display("FAIL reset_mid_pre got=%b exp=%b", obs, 13'b000_011_000_00_1_0);
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs !== V_IDLE || cu_bus.dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid got=%b state=%0d exp=%b state=0", obs, cu_bus.dbg_state, V_IDLE);
    end
    reset = 1'b0;
    cu_bus.start = 1'b1; cu_bus.op = 3'd1; cu_bus.amt = 2'd0;
    step();
    cu_bus.start = 1'b0;
    checks++;
    if (obs !== 13'b100_100_100_00_1_0) begin
      failures++;
      $display("FAIL reset_mid_restart got=%b exp=%b", obs, 13'b100_100_100_00_1_0);
    end
    step();
    checks++;
    if (obs !== V_DONE) begin
      failures++;
      $display("FAIL reset_mid_done got=%b exp=%b", obs, V_DONE);
    end
    step();
  endtask

  task automatic test_random();
    logic [2:0]  r_op;
    logic [1:0]  r_amt;
    logic [12:0] e;
    int          lat;
    for (int r = 0; r < 1000; r++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_amt = 2'($urandom_range(0, 3));
      lat   = (r_op <= 3'd4) ? 2 : ((r_op == 3'd7) ? int'(r_amt) + 3 : int'(r_amt) + 2);
      cu_bus.start = 1'b1; cu_bus.op = r_op; cu_bus.amt = r_amt;
      step();
      for (int k = 1; k <= lat + 1; k++) begin
        e = exp_vec(r_op, r_amt, k);
        checks++;
        if (obs !== e || cu_bus.instr_x > 3'd4 || cu_bus.instr_y > 3'd4 || cu_bus.instr_z > 3'd4
            || cu_bus.busy !== (cu_bus.dbg_state != ST_IDLE)) begin
          failures++;
          $display("FAIL random req=%0d op=%0d amt=%0d cyc=%0d got=%b state=%0d exp=%b",
                   r, r_op, r_amt, k, obs, cu_bus.dbg_state, e);
        end
        if (k <= lat) begin
          // stray requests while busy must be dropped
          cu_bus.start = 1'($urandom_range(0, 1));
          cu_bus.op    = 3'($urandom_range(0, 7));
          cu_bus.amt   = 2'($urandom_range(0, 3));
          step();
        end else begin
          cu_bus.start = 1'b0;
        end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
  endtask

  initial begin
    cu_bus.start = 1'b0;
    cu_bus.op    = 3'd0;
    cu_bus.amt   = 2'd0;
    test_reset();
    test_clr();
    test_shl();
    test_mac_datapath();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
